if_prefetch: RTL and testbench

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/if_pkg.sv | 14 +
 rtl/if_fifo.sv | 65 ++++++
 rtl/if_prefetch.sv | 86 ++++++++
 tb/tb_if_prefetch.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared constants and types for the instruction prefetch unit.
package if_pkg;

  localparam int unsigned DEFAULT_DEPTH    = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  // Instruction SRAM word-address width (byte pc[15:2]).
  localparam int unsigned IM_AW            = 14;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous instruction queue with push, pop and flush; flush wins over both.
module if_fifo
  import if_pkg::*;
#(
  parameter int unsigned Depth = DEFAULT_DEPTH,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  fetch_entry_t    push_data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output logic [CntW-1:0] count_o,
  output fetch_entry_t    head_o
);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  // Next-state for pointers and occupancy.
  always_comb begin
    do_push  = push_i && !flush_i;
    do_pop   = pop_i && !flush_i && (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      // Keep the read pointer so the head keeps showing its last value.
      wr_ptr_d = rd_ptr_q;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // The upstream credit check must never let a full queue be written.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !flush_i && (count_q == CntW'(Depth))));

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: credit-based fetch issue into a 1-cycle SRAM, redirect/flush.
module if_prefetch
  import if_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_data_out,
  output logic             inst_valid,
  output logic [31:0]      inst,
  output logic [31:0]      inst_pc,
  input  logic             inst_ready
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     pending_pc_q, pending_pc_d;
  logic            inflight_q, inflight_d;
  logic [CntW-1:0] count;
  logic [CntW:0]   credit_used;
  logic [31:0]     redirect_base;
  logic            pop, issue, push;
  fetch_entry_t    head, push_entry;
  logic            unused_rpc_lo;

  assign unused_rpc_lo = ^redirect_pc[1:0];

  // Credit check, fetch issue and redirect handling.
  always_comb begin
    pop           = inst_valid && inst_ready;
    // Entries held plus the response still on its way, minus this cycle's pop.
    credit_used   = {1'b0, count} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
    redirect_base = {redirect_pc[31:2], 2'b00};
    issue         = redirect_valid || (credit_used < (CntW + 1)'(DEPTH));
    push          = inflight_q && !redirect_valid;
    push_entry    = '{pc: pending_pc_q, inst: im_data_out};
    im_addr       = redirect_valid ? redirect_pc[15:2] : fetch_pc_q[15:2];
    fetch_pc_d    = fetch_pc_q;
    pending_pc_d  = pending_pc_q;
    inflight_d    = issue;
    if (redirect_valid) begin
      pending_pc_d = redirect_base;
      fetch_pc_d   = redirect_base + 32'd4;
    end else if (issue) begin
      pending_pc_d = fetch_pc_q;
      fetch_pc_d   = fetch_pc_q + 32'd4;
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= '0;
      inflight_q   <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      inflight_q   <= inflight_d;
    end
  end

  if_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .count_o     (count),
    .head_o      (head)
  );

  assign inst_valid = (count != '0);
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: directed scenarios plus random traffic vs a queue model.
module tb_if_prefetch;
  import if_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [13:0] im_addr;
  logic [31:0] im_data_out;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  if_prefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_addr        (im_addr),
    .im_data_out    (im_data_out),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  // Instruction SRAM with 1-cycle read latency.
  logic [31:0] sram [16384];
  always @(posedge clk) im_data_out <= sram[im_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Reference model: what the fetch stream should look like.
  fetch_entry_t m_q[$];
  logic [31:0]  m_fpc;
  logic [31:0]  m_pend;
  logic         m_infl;

  // Outputs observed in the most recent step.
  logic [31:0] obs_addr, obs_pc, obs_inst;
  logic        obs_valid;

  task automatic model_reset();
    m_q.delete();
    m_fpc  = RESET_PC;
    m_pend = '0;
    m_infl = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    int           sz;
    logic         pop, issue;
    logic [31:0]  base;
    logic [13:0]  exp_addr;
    fetch_entry_t e;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    @(negedge clk);
    obs_addr  = 32'(im_addr);
    obs_valid = inst_valid;
    obs_pc    = inst_pc;
    obs_inst  = inst;
    exp_addr  = rv ? rpc[15:2] : m_fpc[15:2];
    check_eq("im_addr", obs_addr, 32'(exp_addr));
    check_eq("inst_valid", 32'(obs_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check_eq("inst_pc", obs_pc, m_q[0].pc);
      check_eq("inst", obs_inst, m_q[0].inst);
    end
    sz  = m_q.size();
    pop = (sz != 0) && rdy;
    if (rv) begin
      base = {rpc[31:2], 2'b00};
      m_q.delete();
      m_pend = base;
      m_fpc  = base + 32'd4;
      m_infl = 1'b1;
    end else begin
      issue = (sz + int'(m_infl) - int'(pop)) < int'(DEPTH);
      if (pop) void'(m_q.pop_front());
      if (m_infl) begin
        e.pc   = m_pend;
        e.inst = sram[m_pend[15:2]];
        m_q.push_back(e);
      end
      if (issue) begin
        m_pend = m_fpc;
        m_fpc  = m_fpc + 32'd4;
      end
      m_infl = issue;
    end
    @(posedge clk);
    #1;
  endtask

  // Step with ready=1 until a valid head appears; report whether one did.
  task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
    logic found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      step(1'b0, 32'h0, 1'b1);
      if (obs_valid) begin
        found = 1'b1;
        check_eq({tag, "_pc"}, obs_pc, exp_pc);
      end
    end
    check_eq({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  logic [31:0] wrap_addr [5];
  logic [31:0] wrap_pc   [3];

  initial begin
    for (int i = 0; i < 16384; i++) sram[i] = 32'(i);
    model_reset();
    #2;
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_inst", inst, 32'd0);
    check_eq("rst_pc", inst_pc, 32'd0);
    check_eq("rst_addr", 32'(im_addr), 32'(RESET_PC[15:2]));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Streaming from reset: one address per cycle, first valid two cycles later.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 1'b1);
      check_eq("stream_addr", obs_addr, 32'(i));
      if (i >= 2) begin
        check_eq("stream_valid", 32'(obs_valid), 32'd1);
        check_eq("stream_pc", obs_pc, 32'((i - 2) * 4));
      end else begin
        check_eq("stream_idle", 32'(obs_valid), 32'd0);
      end
    end

    // Backpressure: four issues then a frozen address and a full queue.
    step(1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0);
    check_eq("bp_addr", obs_addr, 32'd4);
    check_eq("bp_count", 32'(dut.count), 32'd4);
    step(1'b0, 32'h0, 1'b1);
    check_eq("bp_resume_pc", obs_pc, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    check_eq("bp_resume_addr", obs_addr, 32'd5);

    // Redirect with three queued and one in flight.
    step(1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
    check_eq("rd_count", 32'(dut.count), 32'd3);
    step(1'b1, 32'h100, 1'b0);
    check_eq("rd_addr", obs_addr, 32'h40);
    wait_valid("rd", 32'h100);

    // Redirect coinciding with a pop; low pc bits ignored.
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h203, 1'b1);
    check_eq("rdpop_valid", 32'(obs_valid), 32'd1);
    wait_valid("rdpop", 32'h200);

    // Wrap of the 32-bit fetch pc.
    wrap_addr[0] = 32'h3FFE; wrap_addr[1] = 32'h3FFF; wrap_addr[2] = 32'h0000;
    wrap_addr[3] = 32'h0001; wrap_addr[4] = 32'h0002;
    wrap_pc[0] = 32'hFFFF_FFF8; wrap_pc[1] = 32'hFFFF_FFFC; wrap_pc[2] = 32'h0000_0000;
    step(1'b1, 32'hFFFF_FFF8, 1'b1);
    check_eq("wrap_addr", obs_addr, wrap_addr[0]);
    for (int i = 1; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b1);
      check_eq("wrap_addr", obs_addr, wrap_addr[i]);
      if (i >= 2) check_eq("wrap_pc", obs_pc, wrap_pc[i - 2]);
    end

    // Asynchronous reset mid-operation with two entries queued.
    step(1'b1, 32'h40, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check_eq("arst_pre_count", 32'(dut.count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_valid", 32'(inst_valid), 32'd0);
    check_eq("arst_pc", inst_pc, 32'd0);
    check_eq("arst_inst", inst, 32'd0);
    check_eq("arst_addr", 32'(im_addr), 32'(RESET_PC[15:2]));
    for (int i = 0; i < 16384; i++) sram[i] = $urandom;
    model_reset();
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_valid("arst_first", RESET_PC);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 11) == 0), $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
